// File: rtl/hazard_pkg.sv
// Shared types and defaults for the forwarding / load-use hazard unit.
package hazard_pkg;

    localparam int DEF_AW         = 5;
    localparam int DEF_NUM_SRC    = 2;
    localparam int DEF_DEPTH      = 3;
    localparam int DEF_LOAD_READY = 2;
    localparam int DEF_CNT_W      = 16;

    // Widest register address an entry can carry; narrower AW values are zero-extended.
    localparam int RD_MAX_W = 8;

    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                regwrite;
        logic                is_load;
    } stage_entry_t;

    localparam stage_entry_t BUBBLE = '0;

endpackage

// File: rtl/fwd_src_match.sv
// Youngest-producer search for one source operand over the forwardable stages.
module fwd_src_match
    import hazard_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LOAD_READY = DEF_LOAD_READY,
    parameter int SEL_W      = $clog2(DEPTH)
) (
    input  stage_entry_t     stages [DEPTH],
    input  logic [AW-1:0]    rs,
    input  logic             rs_used,
    output logic             hit,
    output logic [SEL_W-1:0] sel,
    output logic             need_stall
);

    logic [RD_MAX_W-1:0] rs_ext;

    assign rs_ext = RD_MAX_W'(rs);

    // Walk oldest to youngest so the lowest matching index is the last writer.
    // The last stage is excluded: it writes the register file at this edge.
    always_comb begin
        hit        = 1'b0;
        sel        = SEL_W'(FWD_RF);
        need_stall = 1'b0;
        for (int j = DEPTH - 2; j >= 0; j--) begin
            if (stages[j].valid && stages[j].regwrite && (stages[j].rd != '0) &&
                (stages[j].rd == rs_ext) && rs_used) begin
                hit        = 1'b1;
                sel        = SEL_W'(j + 1);
                need_stall = stages[j].is_load && ((j + 1) < LOAD_READY);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard unit: tracks in-flight destinations
// from EX onward, registers per-source selects and inserts stall bubbles.
module fwd_hazard_unit
    import hazard_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int NUM_SRC    = DEF_NUM_SRC,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LOAD_READY = DEF_LOAD_READY,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int SEL_W      = $clog2(DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     adv_i,
    input  logic                     flush_i,
    input  logic                     id_valid_i,
    input  logic [AW-1:0]            id_rd_i,
    input  logic                     id_regwrite_i,
    input  logic                     id_is_load_i,
    input  logic [NUM_SRC*AW-1:0]    id_rs_i,
    input  logic [NUM_SRC-1:0]       id_rs_used_i,
    output logic                     stall_o,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel_o,
    output logic                     ex_valid_o,
    output logic [CNT_W-1:0]         stall_cnt_o
);

    stage_entry_t stage_q [DEPTH];
    stage_entry_t id_entry;

    logic [NUM_SRC-1:0]       src_hit;
    logic [NUM_SRC-1:0]       src_stall;
    logic [NUM_SRC*SEL_W-1:0] src_sel;
    logic [NUM_SRC*SEL_W-1:0] next_sel;
    logic                     stall;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_src_match #(
            .AW         (AW),
            .DEPTH      (DEPTH),
            .LOAD_READY (LOAD_READY),
            .SEL_W      (SEL_W)
        ) u_match (
            .stages     (stage_q),
            .rs         (id_rs_i[s*AW +: AW]),
            .rs_used    (id_rs_used_i[s]),
            .hit        (src_hit[s]),
            .sel        (src_sel[s*SEL_W +: SEL_W]),
            .need_stall (src_stall[s])
        );
    end

    // A flushed ID instruction never reaches EX, so it cannot be made to wait.
    assign stall   = (|src_stall) && !flush_i;
    assign stall_o = stall;

    always_comb begin
        id_entry          = BUBBLE;
        id_entry.valid    = id_valid_i && !flush_i;
        id_entry.rd       = RD_MAX_W'(id_rd_i);
        id_entry.regwrite = id_regwrite_i;
        id_entry.is_load  = id_is_load_i;
    end

    always_comb begin
        next_sel = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            next_sel[s*SEL_W +: SEL_W] = src_hit[s] ? src_sel[s*SEL_W +: SEL_W] : SEL_W'(FWD_RF);
        end
        if (flush_i || !id_valid_i) begin
            next_sel = '0;
        end
    end

    // NOTE: the entry array is reset because its valid bits gate every match;
    // non-blocking updates let the shift read the pre-edge value of each stage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= BUBBLE;
            end
            fwd_sel_o   <= '0;
            stall_cnt_o <= '0;
        end else if (adv_i) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                stage_q[k] <= stage_q[k-1];
            end
            if (stall) begin
                stage_q[0] <= BUBBLE;
                fwd_sel_o  <= '0;
                if (stall_cnt_o != '1) begin
                    stall_cnt_o <= stall_cnt_o + CNT_W'(1);
                end
            end else begin
                stage_q[0] <= id_entry;
                fwd_sel_o  <= next_sel;
            end
        end
    end

    assign ex_valid_o = stage_q[0].valid;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit (default geometry, 4-bit stall counter).
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       adv;
    logic       flush;
    logic       id_valid;
    logic [4:0] id_rd;
    logic       id_regwrite;
    logic       id_is_load;
    logic [9:0] id_rs;
    logic [1:0] id_rs_used;
    logic       stall;
    logic [3:0] fwd_sel;
    logic       ex_valid;
    logic [3:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    fwd_hazard_unit #(.CNT_W(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .adv_i         (adv),
        .flush_i       (flush),
        .id_valid_i    (id_valid),
        .id_rd_i       (id_rd),
        .id_regwrite_i (id_regwrite),
        .id_is_load_i  (id_is_load),
        .id_rs_i       (id_rs),
        .id_rs_used_i  (id_rs_used),
        .stall_o       (stall),
        .fwd_sel_o     (fwd_sel),
        .ex_valid_o    (ex_valid),
        .stall_cnt_o   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic v, input logic [4:0] rd, input logic rw, input logic ld,
                         input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used);
        id_valid    = v;
        id_rd       = rd;
        id_regwrite = rw;
        id_is_load  = ld;
        id_rs       = {rs1, rs0};
        id_rs_used  = used;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        issue(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
        repeat (3) tick();
    endtask

    initial begin
        rst   = 1'b1;
        adv   = 1'b1;
        flush = 1'b0;
        issue(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
        #12;
        check("rst_stall", stall, 0);
        check("rst_fwd", fwd_sel, 0);
        check("rst_ex_valid", ex_valid, 0);
        check("rst_cnt", stall_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_stall", stall, 0);

        // ALU producer r3 immediately followed by a consumer of r3 on rs0
        tick();
        issue(1'b1, 5'd3, 1'b1, 1'b0, 5'd1, 5'd2, 2'b11);
        tick();
        issue(1'b1, 5'd6, 1'b1, 1'b0, 5'd3, 5'd4, 2'b11);
        #1;
        check("b2b_alu_stall", stall, 0);
        tick();
        check("b2b_alu_sel", fwd_sel, 4'h1);
        check("b2b_alu_ex_valid", ex_valid, 1);

        // one-instruction gap: r6 producer now sits at pre-shift stage 1
        issue(1'b1, 5'd8, 1'b1, 1'b0, 5'd1, 5'd2, 2'b11);
        tick();
        issue(1'b1, 5'd13, 1'b1, 1'b0, 5'd6, 5'd2, 2'b11);
        tick();
        check("gap1_sel", fwd_sel, 4'h2);

        // two-instruction gap: producer is in the write-back stage, use the register file
        issue(1'b1, 5'd9, 1'b1, 1'b0, 5'd1, 5'd2, 2'b11);
        tick();
        issue(1'b1, 5'd10, 1'b1, 1'b0, 5'd1, 5'd2, 2'b11);
        tick();
        issue(1'b1, 5'd11, 1'b1, 1'b0, 5'd1, 5'd2, 2'b11);
        tick();
        issue(1'b1, 5'd14, 1'b1, 1'b0, 5'd9, 5'd2, 2'b11);
        tick();
        check("gap2_sel", fwd_sel, 4'h0);
        check("gap2_ex_valid", ex_valid, 1);

        // load-use on rs1: one stall cycle, bubble, then select stage 2
        drain();
        issue(1'b1, 5'd5, 1'b1, 1'b1, 5'd1, 5'd2, 2'b11);
        tick();
        issue(1'b1, 5'd12, 1'b1, 1'b0, 5'd4, 5'd5, 2'b11);
        #1;
        check("lu_stall", stall, 1);
        tick();
        check("lu_bubble", ex_valid, 0);
        check("lu_cnt", stall_cnt, 1);
        check("lu_bubble_sel", fwd_sel, 4'h0);
        check("lu_stall_released", stall, 0);
        tick();
        check("lu_sel", fwd_sel, 4'h8);
        check("lu_ex_valid", ex_valid, 1);
        check("lu_cnt_hold", stall_cnt, 1);

        // two producers of r7: the younger one wins
        drain();
        issue(1'b1, 5'd7, 1'b1, 1'b0, 5'd1, 5'd2, 2'b11);
        tick();
        issue(1'b1, 5'd7, 1'b1, 1'b0, 5'd1, 5'd2, 2'b11);
        tick();
        issue(1'b1, 5'd15, 1'b1, 1'b0, 5'd7, 5'd2, 2'b11);
        #1;
        check("young_stall", stall, 0);
        tick();
        check("young_sel", fwd_sel, 4'h1);

        // load to r0 never matches
        drain();
        issue(1'b1, 5'd0, 1'b1, 1'b1, 5'd1, 5'd2, 2'b11);
        tick();
        issue(1'b1, 5'd16, 1'b1, 1'b0, 5'd0, 5'd2, 2'b11);
        #1;
        check("r0_stall", stall, 0);
        tick();
        check("r0_sel", fwd_sel, 4'h0);

        // load r5 consumed only through an unused source slot
        drain();
        issue(1'b1, 5'd5, 1'b1, 1'b1, 5'd1, 5'd2, 2'b11);
        tick();
        issue(1'b1, 5'd17, 1'b1, 1'b0, 5'd5, 5'd3, 2'b10);
        #1;
        check("unused_stall", stall, 0);
        tick();
        check("unused_sel", fwd_sel, 4'h0);
        check("unused_cnt", stall_cnt, 1);

        // load-use with flush: flush wins, bubble, counter untouched
        drain();
        issue(1'b1, 5'd5, 1'b1, 1'b1, 5'd1, 5'd2, 2'b11);
        tick();
        issue(1'b1, 5'd12, 1'b1, 1'b0, 5'd4, 5'd5, 2'b11);
        flush = 1'b1;
        #1;
        check("flush_stall", stall, 0);
        tick();
        check("flush_bubble", ex_valid, 0);
        check("flush_sel", fwd_sel, 4'h0);
        check("flush_cnt", stall_cnt, 1);
        flush = 1'b0;

        // freeze during a load-use stall
        drain();
        issue(1'b1, 5'd5, 1'b1, 1'b1, 5'd1, 5'd2, 2'b11);
        tick();
        issue(1'b1, 5'd12, 1'b1, 1'b0, 5'd4, 5'd5, 2'b11);
        #1;
        check("frz_stall_pre", stall, 1);
        adv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("frz_stall_%0d", i), stall, 1);
            check($sformatf("frz_cnt_%0d", i), stall_cnt, 1);
            check($sformatf("frz_ex_valid_%0d", i), ex_valid, 1);
        end
        adv = 1'b1;
        tick();
        check("frz_resume_cnt", stall_cnt, 2);
        check("frz_resume_bubble", ex_valid, 0);
        check("frz_resume_stall", stall, 0);
        tick();
        check("frz_resume_sel", fwd_sel, 4'h8);

        // self-dependent loads stall every other cycle: 20 more stalls saturate at 15
        drain();
        issue(1'b1, 5'd5, 1'b1, 1'b1, 5'd5, 5'd0, 2'b01);
        repeat (40) tick();
        check("sat_cnt", stall_cnt, 4'hf);
        tick();
        check("sat_stall", stall, 1);
        check("sat_sel", fwd_sel, 4'h2);
        check("sat_cnt_hold", stall_cnt, 4'hf);

        // reset in the middle of a stall clears everything at once
        rst = 1'b1;
        #1;
        check("mid_rst_stall", stall, 0);
        check("mid_rst_fwd", fwd_sel, 0);
        check("mid_rst_ex_valid", ex_valid, 0);
        check("mid_rst_cnt", stall_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_stall", stall, 0);
        tick();
        check("post_rst_ex_valid", ex_valid, 1);
        check("post_rst_cnt", stall_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
